formula_pipe: RTL
=================

// Module: formula_pipe
// PURPOSE
//  Next-generation formula engine: streaming, parametrised pipeline computing one of four signed
//  formulas of a,b,c,d per beat, with ready/valid backpressure and a channel tag carried end to end.
//  Sits between an input sample source and a result consumer. Generalises the fixed vld_in/vld_out
//  formula block in width, depth and mode, and adds per-channel accumulation.
// PARAMETERS
//  WIDTH      8              signed operand width
//  WIDTH_OUT  2*WIDTH+6      signed result width; must be >= 2*WIDTH+3
//  STAGES     3              pipeline latency in cycles; legal range 2..6
//  ID_W       2              channel tag width; 2**ID_W accumulators
// PORTS
//  clk      in   1          clock, rising edge
//  rst      in   1          synchronous reset, active LOW
//  vld_in   in   1          input beat valid
//  rdy_in   out  1          block accepts beat this cycle
//  mode     in   2          formula select, sampled with beat
//  id_in    in   ID_W       channel tag, sampled with beat
//  acc_clr  in   1          clear channel accumulator before adding (mode 2'b11 only)
//  a,b,c,d  in   WIDTH      signed operands
//  vld_out  out  1          result valid
//  rdy_out  in   1          consumer accepts result
//  q        out  WIDTH_OUT  signed result
//  id_out   out  ID_W       tag of result
// BEHAVIOUR
//  - Reset (rst==0 at posedge): all stage valids, vld_out, q, id_out, accumulators -> 0. rdy_in=0
//    combinationally while rst==0; in-flight beats dropped, never emitted.
//  - Modes: 00 q=a*b+c*d; 01 q=(a-b)*(c+d); 10 q=a*a+b*b+c*c+d*d; 11 accumulate (see CONFIGURATION).
//    All math full-precision signed, sign-extended to WIDTH_OUT; modes 00-10 never overflow.
//  - Handshake: beat accepted when vld_in&&rdy_in; result consumed when vld_out&&rdy_out.
//  - Stall: advance = rdy_out || !vld_out; rdy_in = advance && rst. Whole pipe holds when !advance;
//    bubbles not collapsed. Combinational path rdy_out->rdy_in permitted.
//  - Latency exactly STAGES cycles from acceptance to vld_out with no stalls; 1 beat/cycle sustained.
//  - Order preserved; no beat lost or duplicated; q/id_out stable while vld_out&&!rdy_out.
//  - mode, id_in, acc_clr travel with the beat through every stage.
// CONFIGURATION
//  Macro FORMULA_PIPE_ACC_EN:
//  - defined: mode 11 -> s=a*b+c*d; acc[id] = (acc_clr ? 0 : acc[id]) + s, saturated to
//    [-(2**(WIDTH_OUT-1)), 2**(WIDTH_OUT-1)-1]; q = new acc[id]. Update happens on the edge the beat
//    enters the output register, so back-to-back beats on one id chain correctly.
//  - undefined: no accumulator storage; mode 11 behaves as mode 00; acc_clr ignored.
// STRUCTURE
//  - Package formula_pkg: mode_t enum (MODE_MAC, MODE_DIFFSUM, MODE_SQSUM, MODE_ACC),
//    beat struct {mode, id, acc_clr, a,b,c,d}, function sat_add(WIDTH_OUT).
//  - Sub-module formula_acc_bank: 2**ID_W saturating accumulators, clear/add port, sync active-low
//    reset; instantiated only under FORMULA_PIPE_ACC_EN.
//  - Top: stage registers + valid chain + stall logic; products in first half, sums in second.
// TESTING  (WIDTH=8, STAGES=3, WIDTH_OUT=22)
//  1 mode00 a=3,b=-4,c=5,d=6,id=2 -> q=18, id_out=2, vld_out exactly 3 cycles after accept.
//  2 mode10 a=b=c=d=-128 -> q=65536; mode01 a=127,b=-128,c=-128,d=-128 -> q=-65280.
//  3 5-beat burst, rdy_out low 4 cycles mid-burst -> rdy_in low same cycles, 5 results in order,
//    q held stable while stalled, none duplicated.
//  4 ACC_EN: id1 (2,3,0,0)x3 -> q=6,12,18; then acc_clr=1 (1,1,0,0) -> q=1; id0 untouched (=0).
//  5 ACC_EN: 64 beats id3 a=b=-128,c=d=-128 (s=32768) -> q saturates at 2097151, stays there.
//  6 rst low 1 cycle with 2 beats in flight -> vld_out=0 next cycle, beats never emitted,
//    accumulators read 0 on next mode11 (1,1,0,0) -> q=1.

Source files
------------

// File: rtl/formula_pkg.sv
// formula_pkg: shared types and helpers for the formula_pipe streaming engine.
// Optional accumulator mode is enabled by defining FORMULA_PIPE_ACC_EN.
package formula_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int ID_W_DEF      = 2;
  localparam int WIDTH_OUT_DEF = 2*WIDTH_DEF+6;

  typedef enum logic [1:0] {
    MODE_MAC     = 2'b00,  // a*b + c*d
    MODE_DIFFSUM = 2'b01,  // (a-b)*(c+d)
    MODE_SQSUM   = 2'b10,  // a*a + b*b + c*c + d*d
    MODE_ACC     = 2'b11   // per-channel saturating accumulate of a*b + c*d
  } mode_t;

  typedef struct packed {
    mode_t                       mode;
    logic [ID_W_DEF-1:0]         id;
    logic                        acc_clr;
    logic signed [WIDTH_DEF-1:0] a;
    logic signed [WIDTH_DEF-1:0] b;
    logic signed [WIDTH_DEF-1:0] c;
    logic signed [WIDTH_DEF-1:0] d;
  } beat_t;

  // Signed add clamped to the range of a w-bit two's complement value.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                 input logic signed [63:0] y,
                                                 input int w);
    logic signed [63:0] hi, lo, s;
    hi = (64'sd1 <<< (w-1)) - 64'sd1;
    lo = -hi - 64'sd1;
    s  = x + y;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/formula_acc_bank.sv
// formula_acc_bank: 2**ID_W saturating accumulators. Read-modify-write is
// combinational so the new value is presented on sum in the same cycle it is
// written, letting back-to-back beats on one channel chain correctly.
module formula_acc_bank
  import formula_pkg::*;
#(
  parameter int ID_W = 2,
  parameter int W    = 22
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [ID_W-1:0]     id,
  input  logic signed [W-1:0] add,
  output logic signed [W-1:0] sum
);

  logic signed [W-1:0] acc [2**ID_W];
  logic signed [W-1:0] base;

  assign base = clr ? '0 : acc[id];
  assign sum  = W'(sat_add(64'(base), 64'(add), W));

  // Commit the saturated sum for the selected channel; reset clears every channel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2**ID_W; i++) acc[i] <= '0;
    end else if (en) begin
      acc[id] <= sum;
    end
  end

endmodule

// File: rtl/formula_pipe.sv
// formula_pipe: ready/valid pipeline computing one of four signed formulas per
// beat. Stage 1 holds products, later stages hold the sum, the last register is
// the output. Whole pipe stalls together; bubbles are kept, not collapsed.
// Define FORMULA_PIPE_ACC_EN to enable the per-channel accumulate mode (11);
// without it mode 11 computes a*b+c*d and acc_clr is ignored.
module formula_pipe
  import formula_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int WIDTH_OUT = 2*WIDTH+6,
  parameter int STAGES    = 3,
  parameter int ID_W      = 2
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vld_in,
  output logic                        rdy_in,
  input  logic [1:0]                  mode,
  input  logic [ID_W-1:0]             id_in,
  input  logic                        acc_clr,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic signed [WIDTH-1:0]     c,
  input  logic signed [WIDTH-1:0]     d,
  output logic                        vld_out,
  input  logic                        rdy_out,
  output logic signed [WIDTH_OUT-1:0] q,
  output logic [ID_W-1:0]             id_out
);

  localparam int WO = WIDTH_OUT;

  logic              advance, accept;
  logic [STAGES:1]   vld_pipe;
  mode_t             mode_e;
  logic signed [WO-1:0] ax, bx, cx, dx;
  logic signed [WO-1:0] p_d  [4];
  logic signed [WO-1:0] prod [4];
  logic signed [WO-1:0] sum_comb, pre_sum, q_d;
  logic [ID_W-1:0]   id_p [STAGES-1:1];

  assign vld_out = vld_pipe[STAGES];
  assign advance = rdy_out || !vld_out;
  assign rdy_in  = advance && rst;
  assign accept  = vld_in && rdy_in;

  assign mode_e = mode_t'(mode);
  assign ax = WO'(a);
  assign bx = WO'(b);
  assign cx = WO'(c);
  assign dx = WO'(d);

  // Every mode reduces to a sum of up to four full-width products.
  always_comb begin
    p_d[0] = ax * bx;
    p_d[1] = cx * dx;
    p_d[2] = '0;
    p_d[3] = '0;
    case (mode_e)
      MODE_DIFFSUM: begin
        p_d[0] = (ax - bx) * (cx + dx);
        p_d[1] = '0;
      end
      MODE_SQSUM: begin
        p_d[0] = ax * ax;
        p_d[1] = bx * bx;
        p_d[2] = cx * cx;
        p_d[3] = dx * dx;
      end
      default: ;
    endcase
  end

  // Product stage, valid chain and channel-tag chain all shift on advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < 4; i++) prod[i] <= '0;
      for (int s = 1; s < STAGES; s++) id_p[s] <= '0;
      id_out <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      prod     <= p_d;
      id_p[1]  <= id_in;
      for (int s = 2; s < STAGES; s++) id_p[s] <= id_p[s-1];
      id_out   <= id_p[STAGES-1];
    end
  end

  assign sum_comb = prod[0] + prod[1] + prod[2] + prod[3];

  generate
    if (STAGES == 2) begin : g_short
      assign pre_sum = sum_comb;
    end else begin : g_long
      logic signed [WO-1:0] sd [STAGES-1:2];
      // Sum stage plus delay registers up to the one feeding the output.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 2; s < STAGES; s++) sd[s] <= '0;
        end else if (advance) begin
          sd[2] <= sum_comb;
          for (int s = 3; s < STAGES; s++) sd[s] <= sd[s-1];
        end
      end
      assign pre_sum = sd[STAGES-1];
    end
  endgenerate

`ifdef FORMULA_PIPE_ACC_EN
  logic              acc_p [STAGES-1:1];
  logic              clr_p [STAGES-1:1];
  logic              acc_we;
  logic signed [WO-1:0] acc_sum;

  // Accumulate flag and clear request travel alongside the beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 1; s < STAGES; s++) begin
        acc_p[s] <= 1'b0;
        clr_p[s] <= 1'b0;
      end
    end else if (advance) begin
      acc_p[1] <= (mode_e == MODE_ACC);
      clr_p[1] <= acc_clr;
      for (int s = 2; s < STAGES; s++) begin
        acc_p[s] <= acc_p[s-1];
        clr_p[s] <= clr_p[s-1];
      end
    end
  end

  // Accumulator is written on the same edge the beat enters the output register.
  assign acc_we = advance && vld_pipe[STAGES-1] && acc_p[STAGES-1];

  formula_acc_bank #(.ID_W(ID_W), .W(WO)) u_acc (
    .clk (clk),
    .rst (rst),
    .en  (acc_we),
    .clr (clr_p[STAGES-1]),
    .id  (id_p[STAGES-1]),
    .add (pre_sum),
    .sum (acc_sum)
  );

  assign q_d = acc_p[STAGES-1] ? acc_sum : pre_sum;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign q_d = pre_sum;
`endif

  // Output register: loads whenever the pipe advances, holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst)         q <= '0;
    else if (advance) q <= q_d;
  end

endmodule
